spongent_squeeze: RTL and testbench

Squeezing phase of the SPONGENT sponge hash. Sits directly downstream of the absorbing phase: it takes the b-bit state left after the last absorbed block and emits the N-bit digest r bits at a time. Between chunks it drives the shared SPONGENT permutation through that permutation's reset/load/end handshake. The digest is available as a stream of r-bit chunks and as a parallel N-bit register.

---
 rtl/spongent_pkg.sv | 16 +
 rtl/spongent_hash_collector.sv | 26 ++
 rtl/spongent_squeeze.sv | 120 ++++++++++++
 tb/tb_spongent_squeeze.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spongent_pkg.sv
// Shared SPONGENT definitions: squeeze FSM encoding and default sponge geometry.
package spongent_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        PERMUTATION,
        END
    } squeeze_state_t;

    localparam int SPONGENT_N      = 88;
    localparam int SPONGENT_C      = 80;
    localparam int SPONGENT_RATE   = 8;
    localparam int SPONGENT_ROUNDS = 45;

endpackage

// File: rtl/spongent_hash_collector.sv
// Digest accumulator: shifts r-bit chunks in at the LSB end, so the first chunk ends up at the MSBs.
module spongent_hash_collector
    import spongent_pkg::*;
#(
    parameter int N = SPONGENT_N,
    parameter int r = SPONGENT_RATE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic [r-1:0] din,
    output logic [N-1:0] hash
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hash <= '0;
        end else if (clr) begin
            hash <= '0;
        end else if (shift_en) begin
            hash <= {hash[N-r-1:0], din};
        end
    end

endmodule

// File: rtl/spongent_squeeze.sv
// SPONGENT squeezing phase: emits the N-bit digest r bits at a time, driving the shared permutation.
// Optional chunk streaming handshake enabled by defining SPONGENT_SQUEEZE_STREAM_EN.
module spongent_squeeze
    import spongent_pkg::*;
#(
    parameter int N = SPONGENT_N,
    parameter int c = SPONGENT_C,
    parameter int r = SPONGENT_RATE,
    parameter int R = SPONGENT_ROUNDS
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [c+r-1:0] absorbed_state,
    input  logic           end_permutation,
    input  logic [c+r-1:0] permutation_state,
    output logic           rst_permutation,
    output logic [c+r-1:0] permutation_initial_state,
    output logic           chunk_valid,
    output logic [r-1:0]   chunk_data,
    input  logic           chunk_ready,
    output logic [N-1:0]   hash,
    output logic           end_hash,
    output logic           busy
);

    localparam int b      = c + r;
    localparam int NCHUNK = N / r;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // R only sets the external permutation latency; it is checked here for sanity.
    if (((N % r) != 0) || (R < 1) || (N <= r)) begin : g_bad_cfg
        $error("spongent_squeeze: N must be a multiple of r greater than r, and R positive");
    end

    squeeze_state_t fsm_q;
    squeeze_state_t fsm_d;
    logic [b-1:0]     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_eff;
    logic             start_ok;
    logic             emit_accept;
    logic             last_chunk;

`ifdef SPONGENT_SQUEEZE_STREAM_EN
    assign ready_eff   = chunk_ready;
    assign chunk_valid = (fsm_q == EMIT);
    assign chunk_data  = state_q[r-1:0];
`else
    logic unused_chunk_ready;
    assign unused_chunk_ready = chunk_ready;
    assign ready_eff          = 1'b1;
    assign chunk_valid        = 1'b0;
    assign chunk_data         = '0;
`endif

    assign start_ok    = start && ((fsm_q == IDLE) || (fsm_q == END));
    assign emit_accept = (fsm_q == EMIT) && ready_eff;
    assign last_chunk  = (cnt_q == CNT_W'(NCHUNK - 1));

    assign permutation_initial_state = state_q;

    always_comb begin
        fsm_d           = fsm_q;
        rst_permutation = 1'b1;
        end_hash        = 1'b0;
        busy            = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) fsm_d = EMIT;
            end
            EMIT: begin
                busy = 1'b1;
                if (ready_eff) fsm_d = last_chunk ? END : PERMUTATION;
            end
            PERMUTATION: begin
                busy            = 1'b1;
                rst_permutation = 1'b0;
                if (end_permutation) fsm_d = EMIT;
            end
            END: begin
                end_hash = 1'b1;
                if (start) fsm_d = EMIT;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // The last chunk leaves for END without a trailing permutation, so cnt never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            fsm_q <= fsm_d;
            if (start_ok) begin
                state_q <= absorbed_state;
                cnt_q   <= '0;
            end else if (emit_accept && !last_chunk) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if ((fsm_q == PERMUTATION) && end_permutation) begin
                state_q <= permutation_state;
            end
        end
    end

    spongent_hash_collector #(
        .N(N),
        .r(r)
    ) u_collector (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .shift_en(emit_accept),
        .din     (state_q[r-1:0]),
        .hash    (hash)
    );

endmodule

// File: tb/tb_spongent_squeeze.sv
// Directed bench for spongent_squeeze with a +1 permutation model that finishes after 45 rounds.
module tb_spongent_squeeze;

    localparam logic [87:0] H_A5 = 88'hA5A6A7A8A9AAABACADAEAF;
    localparam logic [87:0] H_10 = 88'h101112131415161718191A;
    localparam logic [87:0] H_20 = 88'h202122232425262728292A;
    localparam logic [87:0] H_50 = 88'h505152535455565758595A;
    localparam logic [87:0] H_30_PARTIAL = 88'h0000000000000030313233;
`ifdef SPONGENT_SQUEEZE_STREAM_EN
    localparam int STALL_DELAY = 10;
`else
    localparam int STALL_DELAY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [87:0] absorbed_state;
    logic        end_permutation;
    logic [87:0] permutation_state;
    logic        rst_permutation;
    logic [87:0] permutation_initial_state;
    logic        chunk_valid;
    logic [7:0]  chunk_data;
    logic        chunk_ready;
    logic [87:0] hash;
    logic        end_hash;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0]  rc = '0;
    logic [87:0] ld = '0;
    logic        endp_force = 1'b0;

    always #5 clk = ~clk;

    spongent_squeeze dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .absorbed_state           (absorbed_state),
        .end_permutation          (end_permutation),
        .permutation_state        (permutation_state),
        .rst_permutation          (rst_permutation),
        .permutation_initial_state(permutation_initial_state),
        .chunk_valid              (chunk_valid),
        .chunk_data               (chunk_data),
        .chunk_ready              (chunk_ready),
        .hash                     (hash),
        .end_hash                 (end_hash),
        .busy                     (busy)
    );

    // Permutation model: loads while rst_permutation is high, done when 45 rounds have counted.
    always @(posedge clk) begin
        if (rst_permutation) begin
            rc <= '0;
            ld <= permutation_initial_state;
        end else begin
            rc <= rc + 7'd1;
        end
    end
    assign end_permutation   = (rc == 7'd45) || endp_force;
    assign permutation_state = ld + 88'd1;

    task automatic pulse_start(input logic [87:0] st);
        @(negedge clk);
        absorbed_state = st;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Runs one squeeze from just after the accepting edge; n counts cycles after that edge.
    task automatic squeeze(input logic [7:0] base, input int stall_k, input int stall_len,
                           input bit pulse_starts, input int abort_k, output int n_end);
        int k;
        int sc;
        int pc;
        logic [7:0] exp_b;
        n_end = -1;
        k = 0;
        sc = 0;
        pc = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start = 1'b0;
            endp_force = 1'b0;
            chunk_ready = 1'b1;
            if (end_hash) begin
                n_end = n;
                break;
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL squeeze_busy: busy=%0b at cycle %0d, expected 1", busy, n);
                break;
            end
`ifndef SPONGENT_SQUEEZE_STREAM_EN
            n_checks++;
            if (chunk_valid !== 1'b0 || chunk_data !== 8'h00) begin
                n_fail++;
                $display("FAIL cfg_chunk_tied: valid=%0b data=%h, expected 0/00", chunk_valid, chunk_data);
            end
`endif
            exp_b = base + 8'(k);
            if (rst_permutation) begin
                n_checks++;
                if (permutation_initial_state[7:0] !== exp_b) begin
                    n_fail++;
                    $display("FAIL chunk_state: chunk %0d state byte=%h, expected %h",
                             k, permutation_initial_state[7:0], exp_b);
                end
`ifdef SPONGENT_SQUEEZE_STREAM_EN
                n_checks++;
                if (chunk_valid !== 1'b1 || chunk_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL chunk_out: chunk %0d valid=%0b data=%h, expected 1/%h",
                             k, chunk_valid, chunk_data, exp_b);
                end
`endif
                pc = 0;
                if (k == stall_k && sc < stall_len) begin
                    chunk_ready = 1'b0;
                    endp_force = 1'b1;
                    sc++;
`ifndef SPONGENT_SQUEEZE_STREAM_EN
                    k++;
`endif
                end else begin
                    k++;
                end
            end else begin
`ifdef SPONGENT_SQUEEZE_STREAM_EN
                n_checks++;
                if (chunk_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL perm_valid: chunk_valid=%0b in permutation, expected 0", chunk_valid);
                end
`endif
                pc++;
                if (pulse_starts && pc == 10) begin
                    start = 1'b1;
                    absorbed_state = {80'h0, 8'hEE};
                end
                if (k == abort_k && pc == 20) begin
                    n_end = -2;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        chunk_ready = 1'b1;
        absorbed_state = '0;
        endp_force = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || end_hash !== 1'b0 || rst_permutation !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%0b end_hash=%0b rst_perm=%0b, expected 0/0/1",
                     busy, end_hash, rst_permutation);
        end
        n_checks++;
        if (hash !== 88'h0 || permutation_initial_state !== 88'h0) begin
            n_fail++;
            $display("FAIL reset_data: hash=%h state=%h, expected 0", hash, permutation_initial_state);
        end
        n_checks++;
        if (chunk_valid !== 1'b0 || chunk_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_chunk: valid=%0b data=%h, expected 0/00", chunk_valid, chunk_data);
        end
        rst = 1'b1;
        endp_force = 1'b1;
        repeat (3) @(negedge clk);
        endp_force = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || permutation_initial_state !== 88'h0 || hash !== 88'h0) begin
            n_fail++;
            $display("FAIL idle_endperm: busy=%0b state=%h hash=%h, expected idle zeros",
                     busy, permutation_initial_state, hash);
        end
    endtask

    task automatic test_basic_digest();
        int n_end;
        pulse_start({80'h0123_4567_89AB_CDEF_0F1E, 8'hA5});
        squeeze(8'hA5, -1, 0, 1'b0, -1, n_end);
        n_checks++;
        if (n_end !== 471) begin
            n_fail++;
            $display("FAIL basic_timing: end_hash after %0d cycles, expected 471", n_end);
        end
        n_checks++;
        if (hash !== H_A5) begin
            n_fail++;
            $display("FAIL basic_hash: hash=%h, expected %h", hash, H_A5);
        end
        n_checks++;
        if (busy !== 1'b0 || rst_permutation !== 1'b1 || permutation_initial_state[7:0] !== 8'hAF) begin
            n_fail++;
            $display("FAIL basic_end: busy=%0b rst_perm=%0b state byte=%h, expected 0/1/af",
                     busy, rst_permutation, permutation_initial_state[7:0]);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (end_hash !== 1'b1 || hash !== H_A5) begin
            n_fail++;
            $display("FAIL basic_hold: end_hash=%0b hash=%h, expected 1/%h", end_hash, hash, H_A5);
        end
    endtask

    task automatic test_back_pressure();
        int n_end;
        pulse_start({80'hFFFF_0000_1234_5678_9ABC, 8'hA5});
        squeeze(8'hA5, 3, 10, 1'b0, -1, n_end);
        n_checks++;
        if (n_end !== 471 + STALL_DELAY) begin
            n_fail++;
            $display("FAIL stall_timing: end_hash after %0d cycles, expected %0d", n_end, 471 + STALL_DELAY);
        end
        n_checks++;
        if (hash !== H_A5) begin
            n_fail++;
            $display("FAIL stall_hash: hash=%h, expected %h", hash, H_A5);
        end
    endtask

    task automatic test_busy_guard();
        int n_end;
        pulse_start({80'h0, 8'h20});
        squeeze(8'h20, -1, 0, 1'b1, -1, n_end);
        n_checks++;
        if (n_end !== 471) begin
            n_fail++;
            $display("FAIL guard_timing: end_hash after %0d cycles, expected 471", n_end);
        end
        n_checks++;
        if (hash !== H_20) begin
            n_fail++;
            $display("FAIL guard_hash: hash=%h, expected %h", hash, H_20);
        end
    endtask

    task automatic test_restart();
        int n_end;
        n_checks++;
        if (end_hash !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_pre: end_hash=%0b, expected 1", end_hash);
        end
        pulse_start({80'hABCD, 8'h10});
        n_checks++;
        if (end_hash !== 1'b0 || busy !== 1'b1 || hash !== 88'h0) begin
            n_fail++;
            $display("FAIL restart_clear: end_hash=%0b busy=%0b hash=%h, expected 0/1/0",
                     end_hash, busy, hash);
        end
        squeeze(8'h10, -1, 0, 1'b0, -1, n_end);
        n_checks++;
        if (n_end !== 471 || hash !== H_10) begin
            n_fail++;
            $display("FAIL restart_digest: cycles=%0d hash=%h, expected 471/%h", n_end, hash, H_10);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_end;
        pulse_start({80'h5555, 8'h30});
        squeeze(8'h30, -1, 0, 1'b0, 4, n_end);
        n_checks++;
        if (n_end !== -2 || busy !== 1'b1 || rst_permutation !== 1'b0 || hash !== H_30_PARTIAL) begin
            n_fail++;
            $display("FAIL midrun_pre: abort=%0d busy=%0b rst_perm=%0b hash=%h, expected -2/1/0/%h",
                     n_end, busy, rst_permutation, hash, H_30_PARTIAL);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || end_hash !== 1'b0 || rst_permutation !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_ctrl: busy=%0b end_hash=%0b rst_perm=%0b, expected 0/0/1",
                     busy, end_hash, rst_permutation);
        end
        n_checks++;
        if (hash !== 88'h0 || permutation_initial_state !== 88'h0 ||
            chunk_valid !== 1'b0 || chunk_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midrun_data: hash=%h state=%h valid=%0b data=%h, expected zeros",
                     hash, permutation_initial_state, chunk_valid, chunk_data);
        end
        @(negedge clk);
        rst = 1'b1;
        pulse_start({80'h1, 8'h50});
        squeeze(8'h50, -1, 0, 1'b0, -1, n_end);
        n_checks++;
        if (n_end !== 471 || hash !== H_50) begin
            n_fail++;
            $display("FAIL midrun_digest: cycles=%0d hash=%h, expected 471/%h", n_end, hash, H_50);
        end
    endtask

    initial begin
        test_reset();
        test_basic_digest();
        test_back_pressure();
        test_busy_guard();
        test_restart();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
